// File: rtl/shift_count_register.sv
// shift_count_register: clear/load/inc/dec register with a sequential
// one-bit-per-cycle shifter (logical/arith/rotate), carry and serial out.
// Ports: clk, rst_n; cl, ld/in, inc/dec/step; sh_start/sh_dir/sh_mode/
// sh_amt/ser_in; out, zero, carry, ser_out, busy, done.
package shift_count_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SH_LOG = 2'b00,
    SH_ARI = 2'b01,
    SH_ROT = 2'b10,
    SH_RSV = 2'b11
  } sh_mode_t;

  typedef struct packed {
    logic     dir;
    sh_mode_t mode;
  } sh_ctrl_t;

endpackage

module shift_count_register
  import shift_count_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 5,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cl,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  inc,
  input  logic                  dec,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic                  sh_start,
  input  logic                  sh_dir,
  input  logic [1:0]            sh_mode,
  input  logic [AMT_WIDTH-1:0]  sh_amt,
  input  logic                  ser_in,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  zero,
  output logic                  carry,
  output logic                  ser_out,
  output logic                  busy,
  output logic                  done
);

  localparam int MSB = DATA_WIDTH - 1;

  state_t state_q;
  state_t state_d;

  logic [AMT_WIDTH-1:0] cnt_q;
  logic [AMT_WIDTH-1:0] cnt_d;

  sh_ctrl_t ctrl_q;
  sh_ctrl_t ctrl_d;

  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] out_d;
  logic                  carry_q;
  logic                  carry_d;
  logic                  ser_q;
  logic                  ser_d;
  logic                  busy_q;
  logic                  busy_d;
  logic                  done_q;
  logic                  done_d;

  logic in_idle;
  logic amt_zero;
  logic last;

  logic do_ld;
  logic do_inc;
  logic do_dec;
  logic do_start;
  logic do_shift;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic                  fill;
  logic                  shout;
  logic [DATA_WIDTH-1:0] shifted;

  assign in_idle  = (state_q == IDLE);
  assign amt_zero = (sh_amt == '0);
  assign last     = (cnt_q == AMT_WIDTH'(1));

  // Fixed IDLE priority: cl > ld > inc > dec > sh_start.
  assign do_ld    = in_idle & ~cl & ld;
  assign do_inc   = in_idle & ~cl & ~ld & inc;
  assign do_dec   = in_idle & ~cl & ~ld & ~inc & dec;
  assign do_start = in_idle & ~cl & ~ld & ~inc
                  & ~dec & sh_start;
  assign do_shift = ~in_idle & ~cl;

  // Extra top bit carries the carry-out / borrow.
  assign sum  = {1'b0, out_q} + {1'b0, step};
  assign diff = {1'b0, out_q} - {1'b0, step};

  // One-bit shift of the current value using latched dir/mode.
  always_comb begin
    fill = ser_in;
    unique case (ctrl_q.mode)
      SH_ARI:  fill = ctrl_q.dir ? 1'b0 : out_q[MSB];
      SH_ROT:  fill = ctrl_q.dir ? out_q[MSB] : out_q[0];
      default: fill = ser_in;
    endcase
  end

  always_comb begin
    shifted = '0;
    shout   = 1'b0;
    if (ctrl_q.dir) begin
      shout      = out_q[MSB];
      shifted[0] = fill;
      for (int i = 1; i < DATA_WIDTH; i++)
        shifted[i] = out_q[i-1];
    end else begin
      shout        = out_q[0];
      shifted[MSB] = fill;
      for (int i = 0; i < DATA_WIDTH - 1; i++)
        shifted[i] = out_q[i+1];
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      IDLE: begin
        if (do_start && !amt_zero) begin
          state_d     = SHIFT;
          cnt_d       = sh_amt;
          ctrl_d.dir  = sh_dir;
          ctrl_d.mode = sh_mode_t'(sh_mode);
        end
      end
      SHIFT: begin
        if (cl) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - AMT_WIDTH'(1);
          if (last)
            state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM: outputs. A zero-length shift completes without entering SHIFT.
  always_comb begin
    busy_d = (state_d == SHIFT);
    done_d = (do_start & amt_zero)
           | (do_shift & last);
  end

  // Datapath next value; the selects are mutually exclusive.
  always_comb begin
    out_d   = out_q;
    carry_d = carry_q;
    ser_d   = ser_q;
    unique case (1'b1)
      cl: begin
        out_d   = '0;
        carry_d = 1'b0;
        ser_d   = 1'b0;
      end
      do_ld: begin
        out_d   = in;
        carry_d = 1'b0;
      end
      do_inc: begin
        carry_d = sum[DATA_WIDTH];
        if (SATURATE && sum[DATA_WIDTH])
          out_d = '1;
        else
          out_d = sum[MSB:0];
      end
      do_dec: begin
        carry_d = diff[DATA_WIDTH];
        if (SATURATE && diff[DATA_WIDTH])
          out_d = '0;
        else
          out_d = diff[MSB:0];
      end
      do_shift: begin
        out_d = shifted;
        ser_d = shout;
      end
      default: begin
        out_d   = out_q;
        carry_d = carry_q;
        ser_d   = ser_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out     = out_q;
  assign zero    = (out_q == '0);
  assign carry   = carry_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_count_register.sv
// tb_shift_count_register: wrapping and saturating instances driven in
// parallel; per-cycle expectations queued by a reference model.
module tb_shift_count_register;

  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cl = 1'b0;
  logic          ld = 1'b0;
  logic [W-1:0]  in = '0;
  logic          inc = 1'b0;
  logic          dec = 1'b0;
  logic [W-1:0]  step = '0;
  logic          sh_start = 1'b0;
  logic          sh_dir = 1'b0;
  logic [1:0]    sh_mode = 2'b00;
  logic [AW-1:0] sh_amt = '0;
  logic          ser_in = 1'b0;

  logic [W-1:0] out_w, out_s;
  logic zero_w, zero_s, carry_w, carry_s;
  logic ser_w, ser_s, busy_w, busy_s;
  logic done_w, done_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_count_register #(
    .DATA_WIDTH(W), .AMT_WIDTH(AW), .SATURATE(1'b0)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in),
    .inc(inc), .dec(dec), .step(step), .sh_start(sh_start),
    .sh_dir(sh_dir), .sh_mode(sh_mode), .sh_amt(sh_amt),
    .ser_in(ser_in), .out(out_w), .zero(zero_w),
    .carry(carry_w), .ser_out(ser_w), .busy(busy_w),
    .done(done_w)
  );

  shift_count_register #(
    .DATA_WIDTH(W), .AMT_WIDTH(AW), .SATURATE(1'b1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in),
    .inc(inc), .dec(dec), .step(step), .sh_start(sh_start),
    .sh_dir(sh_dir), .sh_mode(sh_mode), .sh_amt(sh_amt),
    .ser_in(ser_in), .out(out_s), .zero(zero_s),
    .carry(carry_s), .ser_out(ser_s), .busy(busy_s),
    .done(done_s)
  );

  typedef struct packed {
    logic [1:0][W-1:0] out;
    logic [1:0]        carry;
    logic [1:0]        ser;
    logic              busy;
    logic              done;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 wraps, index 1 saturates.
  logic [W-1:0] m_out [2];
  logic         m_carry [2];
  logic         m_ser [2];
  int           m_left;
  logic         m_dir;
  logic [1:0]   m_mode;
  logic         m_done;

  task automatic shift_one(input int k);
    logic [W-1:0] x;
    logic f;
    x = m_out[k];
    if (m_dir) begin
      m_ser[k] = x[W-1];
      case (m_mode)
        2'b01:   f = 1'b0;
        2'b10:   f = x[W-1];
        default: f = ser_in;
      endcase
      m_out[k] = (x << 1) | W'(f);
    end else begin
      m_ser[k] = x[0];
      case (m_mode)
        2'b01:   f = x[W-1];
        2'b10:   f = x[0];
        default: f = ser_in;
      endcase
      m_out[k] = (x >> 1) | (W'(f) << (W-1));
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = '0;
      m_carry[k] = 1'b0;
      m_ser[k] = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    int s;
    m_clear();
    m_left = 0;
    m_dir = 1'b0;
    m_mode = 2'b00;
    m_done = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_clear();
        m_left = 0;
        m_done = 1'b0;
      end else if (m_left > 0) begin
        if (cl) begin
          m_clear();
          m_left = 0;
          m_done = 1'b0;
        end else begin
          for (int k = 0; k < 2; k++) shift_one(k);
          m_left--;
          m_done = (m_left == 0);
        end
      end else begin
        m_done = 1'b0;
        if (cl) begin
          m_clear();
        end else if (ld) begin
          for (int k = 0; k < 2; k++) begin
            m_out[k] = in;
            m_carry[k] = 1'b0;
          end
        end else if (inc) begin
          for (int k = 0; k < 2; k++) begin
            s = int'(m_out[k]) + int'(step);
            m_carry[k] = (s > 65535);
            if (k == 1 && s > 65535) m_out[k] = '1;
            else m_out[k] = W'(s);
          end
        end else if (dec) begin
          for (int k = 0; k < 2; k++) begin
            m_carry[k] = (step > m_out[k]);
            if (k == 1 && step > m_out[k]) m_out[k] = '0;
            else m_out[k] = m_out[k] - step;
          end
        end else if (sh_start) begin
          if (sh_amt == 0) m_done = 1'b1;
          else begin
            m_left = int'(sh_amt);
            m_dir = sh_dir;
            m_mode = sh_mode;
          end
        end
      end
      e.out[0] = m_out[0];
      e.out[1] = m_out[1];
      e.carry = {m_carry[1], m_carry[0]};
      e.ser = {m_ser[1], m_ser[0]};
      e.busy = (m_left > 0);
      e.done = m_done;
      q.push_back(e);
    end
  end

  // Monitor: compare every cycle just after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        chk("queue_empty", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk("out_wrap", out_w, e.out[0]);
        chk("out_sat", out_s, e.out[1]);
        chk("carry_wrap", carry_w, e.carry[0]);
        chk("carry_sat", carry_s, e.carry[1]);
        chk("ser_wrap", ser_w, e.ser[0]);
        chk("ser_sat", ser_s, e.ser[1]);
        chk("zero_wrap", zero_w, e.out[0] == '0);
        chk("zero_sat", zero_s, e.out[1] == '0);
        chk("busy_wrap", busy_w, e.busy);
        chk("busy_sat", busy_s, e.busy);
        chk("done_wrap", done_w, e.done);
        chk("done_sat", done_s, e.done);
      end
    end
  end

  task automatic do_ld(input logic [W-1:0] v);
    ld = 1'b1;
    in = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic do_inc(input logic [W-1:0] s);
    inc = 1'b1;
    step = s;
    @(negedge clk);
    inc = 1'b0;
  endtask

  task automatic do_dec(input logic [W-1:0] s);
    dec = 1'b1;
    step = s;
    @(negedge clk);
    dec = 1'b0;
  endtask

  task automatic start(input logic d, input logic [1:0] m,
                       input int n);
    sh_start = 1'b1;
    sh_dir = d;
    sh_mode = m;
    sh_amt = AW'(n);
    @(negedge clk);
    sh_start = 1'b0;
  endtask

  task automatic run_shift(input logic d, input logic [1:0] m,
                           input int n,
                           output int nb, output int nd);
    start(d, m, n);
    nb = 0;
    nd = 0;
    repeat (n + 3) begin
      nb += int'(busy_w);
      nd += int'(done_w);
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, nd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_out", out_w, 16'h0000);

    do_ld(16'hA5C3);
    chk("ld_out", out_w, 16'hA5C3);
    chk("ld_zero", zero_w, 1'b0);
    chk("ld_carry", carry_w, 1'b0);

    do_ld(16'hFFFE);
    do_inc(16'd3);
    chk("inc_wrap", out_w, 16'h0001);
    chk("inc_sat", out_s, 16'hFFFF);
    chk("inc_carry", {carry_s, carry_w}, 2'b11);

    do_ld(16'h0001);
    do_dec(16'd2);
    chk("dec_wrap", out_w, 16'hFFFF);
    chk("dec_sat", out_s, 16'h0000);
    chk("dec_borrow", {carry_s, carry_w}, 2'b11);

    do_ld(16'h8001);
    run_shift(1'b0, 2'b01, 4, nb, nd);
    chk("ari_r4_out", out_w, 16'hF800);
    chk("ari_r4_ser", ser_w, 1'b0);
    chk("ari_r4_busy", nb, 4);
    chk("ari_r4_done", nd, 1);

    do_ld(16'h8001);
    run_shift(1'b1, 2'b10, 4, nb, nd);
    chk("rot_l4_out", out_w, 16'h0018);

    do_ld(16'h8001);
    ser_in = 1'b1;
    run_shift(1'b0, 2'b00, 4, nb, nd);
    ser_in = 1'b0;
    chk("log_r4_out", out_w, 16'hF800);
    chk("log_r4_busy", nb, 4);
    chk("log_r4_done", nd, 1);

    do_ld(16'h1234);
    run_shift(1'b0, 2'b00, 0, nb, nd);
    chk("amt0_out", out_w, 16'h1234);
    chk("amt0_busy", nb, 0);
    chk("amt0_done", nd, 1);

    do_ld(16'hB00C);
    run_shift(1'b1, 2'b10, 16, nb, nd);
    chk("rot16_out", out_w, 16'hB00C);
    chk("rot16_busy", nb, 16);
    chk("rot16_done", nd, 1);

    // ld/inc ignored while busy, then abort with cl.
    do_ld(16'h00FF);
    start(1'b1, 2'b00, 8);
    ld = 1'b1; in = 16'h1111;
    inc = 1'b1; step = 16'h0001;
    @(negedge clk);
    ld = 1'b0; inc = 1'b0;
    chk("busy_ign", out_w, 16'h01FE);
    @(negedge clk);
    cl = 1'b1;
    @(negedge clk);
    cl = 1'b0;
    chk("abort_out", out_w, 16'h0000);
    chk("abort_busy", busy_w, 1'b0);
    nd = 0;
    repeat (10) begin
      nd += int'(done_w);
      @(negedge clk);
    end
    chk("abort_nodone", nd, 0);

    do_ld(16'h5555);
    cl = 1'b1; ld = 1'b1; inc = 1'b1;
    in = 16'h7777; step = 16'h0001;
    @(negedge clk);
    cl = 1'b0; ld = 1'b0; inc = 1'b0;
    chk("prio_cl", out_w, 16'h0000);
    ld = 1'b1; inc = 1'b1; in = 16'h7777;
    @(negedge clk);
    ld = 1'b0; inc = 1'b0;
    chk("prio_ld", out_w, 16'h7777);

    // Back-to-back shifts with sh_start in the done cycle.
    start(1'b0, 2'b10, 3);
    repeat (3) @(negedge clk);
    chk("b2b_done", done_w, 1'b1);
    chk("b2b_idle", busy_w, 1'b0);
    start(1'b1, 2'b10, 2);
    chk("b2b_busy", busy_w, 1'b1);
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of a shift.
    do_ld(16'hC3C3);
    start(1'b1, 2'b00, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_out", out_w, 16'h0000);
    chk("rst_busy", busy_w, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      nd += int'(done_w);
      @(negedge clk);
    end
    chk("rst_nodone", nd, 0);

    // Randomized traffic; the scoreboard checks every cycle.
    repeat (3000) begin
      rst_n = ($urandom_range(0, 999) >= 3);
      cl = ($urandom_range(0, 99) < 3);
      ld = ($urandom_range(0, 99) < 12);
      inc = ($urandom_range(0, 99) < 20);
      dec = ($urandom_range(0, 99) < 20);
      sh_start = ($urandom_range(0, 99) < 25);
      sh_dir = 1'($urandom);
      sh_mode = 2'($urandom);
      ser_in = 1'($urandom);
      if ($urandom_range(0, 3) == 0) sh_amt = AW'($urandom);
      else sh_amt = AW'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: in = 16'hFFFF;
        1: in = 16'h0000;
        default: in = W'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0)
        step = W'($urandom_range(0, 4));
      else
        step = W'($urandom);
      @(negedge clk);
    end

    rst_n = 1'b1;
    cl = 1'b0; ld = 1'b0; inc = 1'b0;
    dec = 1'b0; sh_start = 1'b0;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
